scan_start_mux: RTL and testbench
=================================

# scan_start_mux

Parametrised successor to the two-way scan start selector. It routes one of `NCH` scan-start sources onto a single registered `s_start` line in the `dds` clock domain. Channel changes are glitch-free: an asserted start is drained, then a guard gap is enforced before the new source is connected. An optional rising-edge mode converts the selected level into one-cycle start pulses for the downstream scan sequencer.

## Interface
- `NCH`, 4: number of start sources, 2..16.
- `SELW`, 2: select width; must satisfy 2^`SELW` >= `NCH`.
- `GUARD`, 4: forced-low gap, in cycles, between channels; 1..255.
- `DRAIN_MAX`, 64: maximum cycles spent waiting for the old start to drop; 1..65535.
- `PULSE_MODE`, 0: 0 = level pass-through; 1 = one-cycle pulse on each rising edge of the selected source.

Ports:
- `dds` in 1: clock. One clock only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: output enable; 0 forces `s_start` low.
- `change` in `SELW`: requested channel index.
- `s_startin` in `NCH`: start sources; bit i is channel i.
- `s_start` out 1: registered selected start.
- `active_ch` out `SELW`: channel currently connected.
- `switching` out 1: high while in DRAIN or GUARD.
- `sw_done` out 1: one-cycle pulse when a switch completes.

## Operation
- All `s_startin` bits are registered once (`in_q`) before any use. No other synchronisation is done.
- Reset state: RUN, `active_ch`=0, `s_start`=0, `switching`=0, `sw_done`=0, edge history=0, counters=0.
- Switch request: in RUN, `change` != `active_ch` and `change` < `NCH`. `change` >= `NCH` is ignored and the current channel is held.
- The target is latched at request time. `change` is ignored during DRAIN/GUARD. After returning to RUN it is compared again, so a later change starts a fresh switch.
- RUN:
  - Level mode: `s_start` <= `in_q[active_ch]` & `en`.
  - Pulse mode: `s_start` <= `in_q[active_ch]` & ~`hist` & `en`; `hist` <= `in_q[active_ch]` every cycle.
  - On a request: go to DRAIN if `s_start` is currently 1, else go to GUARD.
- DRAIN:
  - `s_start` keeps following the old channel, same rule as RUN.
  - Leave for GUARD when the old channel's next `s_start` value would be 0, or after `DRAIN_MAX` cycles. On timeout, force `s_start` to 0.
- GUARD:
  - `s_start`=0 for exactly `GUARD` cycles.
  - On the last guard cycle: `active_ch` <= target, `hist` <= `in_q[target]`, `sw_done`=1, return to RUN.
  - Loading `hist` this way means a source that is already high produces no pulse in pulse mode.
- `en`=0 only masks `s_start`. State, counters and `hist` keep running, so switches still complete while disabled.
- Reset asserted mid-switch: everything returns to reset values immediately. The pending target is discarded.

## Timing
- Source to `s_start` latency: 2 `dds` cycles (`in_q` stage plus output register), in both modes.
- `switching` is registered. It rises the cycle after the request is sampled and falls in the same cycle that `sw_done` is high.
- Switch with old start low: request sampled at edge t, GUARD occupies t+1..t+`GUARD`, `active_ch` and `sw_done` update at edge t+`GUARD`. The first new-channel `s_start` value appears at edge t+`GUARD`+1.
- Switch with old start high: add the DRAIN cycles; at most `DRAIN_MAX`.
- `s_start` is never high in two consecutive cycles that belong to different channels. The minimum low gap across a switch is `GUARD` cycles.
- Pulse mode: pulses are exactly 1 cycle wide. A source held high produces one pulse only.

## Test plan
- Reset/level pass-through: hold `rst_n`=0, drive `s_startin`=4'b1111 → all outputs 0. Release, `change`=0, toggle bit0 → `s_start` mirrors it 2 cycles later; `active_ch`=0.
- Clean switch: `s_startin[0]`=0, `GUARD`=4, set `change`=2 at cycle t → `switching` high t+1..t+4, `sw_done` at t+4, `active_ch`=2, `s_start` follows bit2 from t+5.
- Drain: bit0 high for 10 more cycles, then request channel 1 → `s_start` stays high until bit0 drops, then 4 low cycles, then channel 1. Repeat with bit0 stuck high and `DRAIN_MAX`=8 → forced low after 8 cycles.
- Pulse mode (`PULSE_MODE`=1): bit3 high for 20 cycles → single one-cycle `s_start`. Switch to channel 3 while bit3 is already high → no pulse until bit3 falls and rises again.
- Invalid and mid-switch changes: `NCH`=3, `change`=3 → no switch, `active_ch` unchanged. During GUARD toward channel 1, change to 2 → completes to 1 (`sw_done`), then a second full switch to 2.
- Reset mid-DRAIN: assert `rst_n` low asynchronously → `s_start`=0 and `switching`=0 within the same cycle; after release, `active_ch`=0.

Source files
------------

// File: rtl/scan_start_mux_if.sv
// rtl/scan_start_mux_if.sv - start source, select and status bundle for scan_start_mux
interface scan_start_mux_if #(
  parameter int NCH  = 4,
  parameter int SELW = 2
);
  logic            en;
  logic [SELW-1:0] change;
  logic [NCH-1:0]  s_startin;
  logic            s_start;
  logic [SELW-1:0] active_ch;
  logic            switching;
  logic            sw_done;

  modport master (
    output en, change, s_startin,
    input  s_start, active_ch, switching, sw_done
  );

  modport slave (
    input  en, change, s_startin,
    output s_start, active_ch, switching, sw_done
  );
endinterface

// File: rtl/scan_start_mux.sv
// rtl/scan_start_mux.sv - glitch-free NCH-way scan start selector with drain/guard switching
module scan_start_mux #(
  parameter int NCH        = 4,
  parameter int SELW       = 2,
  parameter int GUARD      = 4,
  parameter int DRAIN_MAX  = 64,
  parameter int PULSE_MODE = 0
) (
  input  logic            dds,
  input  logic            rst_n,
  scan_start_mux_if.slave bus
);
  localparam int          PADW       = 2 ** SELW;
  localparam logic [SELW:0] NCH_W    = NCH[SELW:0];
  localparam logic [15:0] GUARD_LAST = 16'(GUARD - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_GUARD} state_t;

  state_t          state;
  logic [NCH-1:0]  in_q;
  logic [SELW-1:0] active_q;
  logic [SELW-1:0] target;
  logic            hist;
  logic [15:0]     cnt;
  logic            s_start_q;
  logic            switching_q;
  logic            sw_done_q;

  logic [PADW-1:0] in_pad;
  logic            sel_lvl;
  logic            tgt_lvl;
  logic            nxt_start;
  logic            req;

  // Padding to a power of two keeps the channel index full-width and in range.
  always_comb begin
    in_pad            = '0;
    in_pad[NCH-1:0]   = in_q;
    sel_lvl           = in_pad[active_q];
    tgt_lvl           = in_pad[target];
    nxt_start         = ((PULSE_MODE != 0) ? (sel_lvl & ~hist) : sel_lvl) & bus.en;
    req               = (bus.change != active_q) && ({1'b0, bus.change} < NCH_W);
  end

  always_ff @(posedge dds or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      in_q        <= '0;
      active_q    <= '0;
      target      <= '0;
      hist        <= 1'b0;
      cnt         <= '0;
      s_start_q   <= 1'b0;
      switching_q <= 1'b0;
      sw_done_q   <= 1'b0;
    end else begin
      in_q      <= bus.s_startin;
      sw_done_q <= 1'b0;
      case (state)
        ST_RUN: begin
          s_start_q <= nxt_start;
          hist      <= sel_lvl;
          if (req) begin
            target      <= bus.change;
            switching_q <= 1'b1;
            cnt         <= '0;
            state       <= s_start_q ? ST_DRAIN : ST_GUARD;
          end
        end
        ST_DRAIN: begin
          hist <= sel_lvl;
          // Leave as soon as the old start would drop, or force it low on timeout.
          if (!nxt_start || cnt == DRAIN_LAST) begin
            s_start_q <= 1'b0;
            cnt       <= '0;
            state     <= ST_GUARD;
          end else begin
            s_start_q <= 1'b1;
            cnt       <= cnt + 16'd1;
          end
        end
        ST_GUARD: begin
          s_start_q <= 1'b0;
          if (cnt == GUARD_LAST) begin
            active_q    <= target;
            hist        <= tgt_lvl;
            sw_done_q   <= 1'b1;
            switching_q <= 1'b0;
            cnt         <= '0;
            state       <= ST_RUN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.s_start   = s_start_q;
  assign bus.active_ch = active_q;
  assign bus.switching = switching_q;
  assign bus.sw_done   = sw_done_q;
endmodule

// File: tb/tb_scan_start_mux.sv
// tb/tb_scan_start_mux.sv - randomized scoreboard bench for scan_start_mux (level and pulse instances)
module tb_scan_start_mux;
  logic dds = 1'b0;
  logic rst_n;
  always #5 dds = ~dds;

  scan_start_mux_if #(.NCH(4), .SELW(2)) bus0 ();
  scan_start_mux_if #(.NCH(3), .SELW(2)) bus1 ();

  scan_start_mux #(.NCH(4), .SELW(2), .GUARD(4), .DRAIN_MAX(8), .PULSE_MODE(0)) dut0 (
    .dds(dds), .rst_n(rst_n), .bus(bus0));
  scan_start_mux #(.NCH(3), .SELW(2), .GUARD(3), .DRAIN_MAX(5), .PULSE_MODE(1)) dut1 (
    .dds(dds), .rst_n(rst_n), .bus(bus1));

  typedef struct packed {
    bit       s;
    bit [1:0] act;
    bit       sw;
    bit       done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  int cfg_nch[2]   = '{4, 3};
  int cfg_guard[2] = '{4, 3};
  int cfg_dmax[2]  = '{8, 5};
  bit cfg_pulse[2] = '{1'b0, 1'b1};

  // Reference: guard/drain as countdowns of remaining cycles, target pending while busy.
  bit [3:0] m_inq[2];
  bit       m_out[2];
  bit       m_busy[2];
  bit       m_done[2];
  bit       m_prev[2];
  int       m_act[2];
  int       m_tgt[2];
  int       m_gleft[2];
  int       m_dleft[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_inq[d] = '0; m_out[d] = 0; m_busy[d] = 0; m_done[d] = 0; m_prev[d] = 0;
      m_act[d] = 0; m_tgt[d] = 0; m_gleft[d] = 0; m_dleft[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit en, input int chg, input bit [3:0] sin);
    bit   sel;
    bit   want;
    exp_t e;
    sel  = m_inq[d][m_act[d]];
    want = en && (cfg_pulse[d] ? (sel && !m_prev[d]) : sel);
    m_done[d] = 0;
    if (m_gleft[d] > 0) begin
      m_out[d] = 0;
      m_gleft[d]--;
      if (m_gleft[d] == 0) begin
        m_act[d]  = m_tgt[d];
        m_prev[d] = m_inq[d][m_tgt[d]];
        m_done[d] = 1;
        m_busy[d] = 0;
      end
    end else if (m_dleft[d] > 0) begin
      m_prev[d] = sel;
      if (!want || m_dleft[d] == 1) begin
        m_out[d]   = 0;
        m_dleft[d] = 0;
        m_gleft[d] = cfg_guard[d];
      end else begin
        m_out[d] = 1;
        m_dleft[d]--;
      end
    end else begin
      if (chg != m_act[d] && chg < cfg_nch[d]) begin
        m_tgt[d]  = chg;
        m_busy[d] = 1;
        if (m_out[d]) m_dleft[d] = cfg_dmax[d];
        else          m_gleft[d] = cfg_guard[d];
      end
      m_out[d]  = want;
      m_prev[d] = sel;
    end
    m_inq[d] = (d == 1) ? {1'b0, sin[2:0]} : sin;
    e.s = m_out[d]; e.act = 2'(m_act[d]); e.sw = m_busy[d]; e.done = m_done[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit en, input int chg, input bit [3:0] sin);
    @(negedge dds);
    bus0.en = en; bus0.change = 2'(chg); bus0.s_startin = sin;
    bus1.en = en; bus1.change = 2'(chg); bus1.s_startin = sin[2:0];
    if (rst_n) begin
      model_step(0, en, chg, sin);
      model_step(1, en, chg, sin);
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, " d0.s_start"},   int'(bus0.s_start),   0);
    cmp({tag, " d0.switching"}, int'(bus0.switching), 0);
    cmp({tag, " d0.active_ch"}, int'(bus0.active_ch), 0);
    cmp({tag, " d0.sw_done"},   int'(bus0.sw_done),   0);
    cmp({tag, " d1.s_start"},   int'(bus1.s_start),   0);
    cmp({tag, " d1.switching"}, int'(bus1.switching), 0);
    cmp({tag, " d1.active_ch"}, int'(bus1.active_ch), 0);
    cmp({tag, " d1.sw_done"},   int'(bus1.sw_done),   0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge dds);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("d0.s_start",   int'(bus0.s_start),   int'(e.s));
        cmp("d0.active_ch", int'(bus0.active_ch), int'(e.act));
        cmp("d0.switching", int'(bus0.switching), int'(e.sw));
        cmp("d0.sw_done",   int'(bus0.sw_done),   int'(e.done));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("d1.s_start",   int'(bus1.s_start),   int'(e.s));
        cmp("d1.active_ch", int'(bus1.active_ch), int'(e.act));
        cmp("d1.switching", int'(bus1.switching), int'(e.sw));
        cmp("d1.sw_done",   int'(bus1.sw_done),   int'(e.done));
      end
    end
  end

  initial begin : driver
    bit [3:0] cur_sin;
    int       cur_chg;
    bit       cur_en;
    rst_n = 1'b0;
    bus0.en = 1'b1; bus0.change = '0; bus0.s_startin = 4'b1111;
    bus1.en = 1'b1; bus1.change = '0; bus1.s_startin = 3'b111;
    model_reset();
    repeat (3) @(posedge dds);
    @(negedge dds);
    check_zero("reset");
    @(posedge dds);
    #1 rst_n = 1'b1;

    // Pass-through on channel 0.
    for (int i = 0; i < 8; i++) step(1'b1, 0, 4'(i % 2));
    // Clean switch to channel 2, then exercise bit 2.
    for (int i = 0; i < 8; i++) step(1'b1, 2, 4'b0000);
    for (int i = 0; i < 6; i++) step(1'b1, 2, (i % 3 == 0) ? 4'b0100 : 4'b0000);
    // Back to 0, then drain a held start into channel 1.
    for (int i = 0; i < 8; i++) step(1'b1, 0, 4'b0000);
    for (int i = 0; i < 10; i++) step(1'b1, 0, 4'b0001);
    for (int i = 0; i < 4; i++) step(1'b1, 1, 4'b0001);
    for (int i = 0; i < 10; i++) step(1'b1, 1, 4'b0010);
    // Stuck-high source forces the drain timeout.
    for (int i = 0; i < 10; i++) step(1'b1, 0, 4'b1111);
    for (int i = 0; i < 20; i++) step(1'b1, 1, 4'b1111);
    // Pulse on a held source, and a switch onto an already-high source.
    for (int i = 0; i < 8; i++) step(1'b1, 2, 4'b0000);
    for (int i = 0; i < 20; i++) step(1'b1, 2, 4'b0100);
    for (int i = 0; i < 6; i++) step(1'b1, 0, 4'b0101);
    for (int i = 0; i < 10; i++) step(1'b1, 2, 4'b0101);
    for (int i = 0; i < 4; i++) step(1'b1, 2, 4'b0001);
    for (int i = 0; i < 4; i++) step(1'b1, 2, 4'b0101);
    // Out-of-range select on the 3-channel instance; change during guard.
    for (int i = 0; i < 8; i++) step(1'b1, 3, 4'b1010);
    for (int i = 0; i < 8; i++) step(1'b1, 0, 4'b0000);
    for (int i = 0; i < 2; i++) step(1'b1, 1, 4'b0000);
    for (int i = 0; i < 16; i++) step(1'b1, 2, 4'b0000);
    // Disabled output while a switch completes.
    for (int i = 0; i < 12; i++) step(1'b0, 0, 4'b1111);
    for (int i = 0; i < 4; i++) step(1'b1, 0, 4'b1111);

    // Reset asserted mid-drain.
    for (int i = 0; i < 8; i++) step(1'b1, 0, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b1, 0, 4'b0001);
    for (int i = 0; i < 3; i++) step(1'b1, 1, 4'b0001);
    @(negedge dds);
    cmp("pre-reset d0.s_start",   int'(bus0.s_start),   1);
    cmp("pre-reset d0.switching", int'(bus0.switching), 1);
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1 check_zero("async reset");
    model_reset();
    repeat (2) @(posedge dds);
    #1 rst_n = 1'b1;
    step(1'b1, 0, 4'b0001);
    cmp("post-reset d0.active_ch", int'(bus0.active_ch), 0);

    // Randomized traffic with slowly changing sources.
    cur_sin = 4'b0000; cur_chg = 0; cur_en = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(5) == 0) cur_sin[$urandom_range(3)] = ~cur_sin[$urandom_range(3)];
      if ($urandom_range(11) == 0) cur_chg = int'($urandom_range(3));
      if ($urandom_range(29) == 0) cur_en = ~cur_en;
      if (!cur_en && $urandom_range(3) == 0) cur_en = 1'b1;
      step(cur_en, cur_chg, cur_sin);
    end
    repeat (3) @(posedge dds);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
